serial_magnitude_comparator: RTL and testbench

SERIAL_MAGNITUDE_COMPARATOR -- requirements
Module: serial_magnitude_comparator

---
 rtl/cmp_pkg.sv | 19 +
 rtl/cmp_digit.sv | 22 ++
 rtl/serial_magnitude_comparator.sv | 105 ++++++++++
 tb/tb_serial_magnitude_comparator.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Types and constants shared by the serial magnitude comparator and its digit compare.
// Results travel as a one-hot {gt, eq, lt} triple.
package cmp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [2:0] GT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] LT = 3'b001;

  // A digit counter always needs at least one bit, even for a single-digit operand.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cmp_digit.sv
// Combinational unsigned compare of one DIGIT-bit slice of each operand.
module cmp_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] da,
  input  logic [DIGIT-1:0] db,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  logic [DIGIT-1:0] diff;

  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_diff
    assign diff[gi] = da[gi] ^ db[gi];
  end

  assign eq = ~|diff;
  assign gt = (da > db);
  assign lt = (da < db);

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Compares two WIDTH-bit operands one DIGIT-bit slice per clock, most significant first.
// Signed operands are mapped to offset binary at capture so the datapath stays unsigned.
module serial_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(N - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_reg;
  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             found_reg;
  logic [2:0]       first_reg;
  logic [2:0]       res_reg;
  logic             done_reg;

  logic       dig_gt;
  logic       dig_eq;
  logic       dig_lt;
  logic [2:0] dig_res;
  logic       finish;
  logic [2:0] final_res;

  cmp_digit #(.DIGIT(DIGIT)) u_cmp_digit (
    .da (a_sh_reg[WIDTH-1 -: DIGIT]),
    .db (b_sh_reg[WIDTH-1 -: DIGIT]),
    .gt (dig_gt),
    .eq (dig_eq),
    .lt (dig_lt)
  );

  assign dig_res = {dig_gt, dig_eq, dig_lt};
  assign finish  = (cnt_reg == LAST) || ((EARLY_EXIT != 0) && !dig_eq);
  // Without early exit the earliest mismatch wins over anything seen later.
  assign final_res = found_reg ? first_reg : dig_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      cnt_reg   <= '0;
      found_reg <= 1'b0;
      first_reg <= '0;
      res_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sh_reg  <= signed_mode ? (a ^ MSB_MASK) : a;
            b_sh_reg  <= signed_mode ? (b ^ MSB_MASK) : b;
            cnt_reg   <= '0;
            found_reg <= 1'b0;
            first_reg <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          a_sh_reg <= a_sh_reg << DIGIT;
          b_sh_reg <= b_sh_reg << DIGIT;
          cnt_reg  <= cnt_reg + 1'b1;
          if (!found_reg && !dig_eq) begin
            found_reg <= 1'b1;
            first_reg <= dig_res;
          end
          if (finish) begin
            res_reg   <= final_res;
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = (state_reg == RUN);
  assign done = done_reg;
  assign gt   = res_reg[2];
  assign eq   = res_reg[1];
  assign lt   = res_reg[0];

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed and randomised checks of the serial comparator with early exit on, off, and N=1.
module tb_serial_magnitude_comparator;

  localparam logic [2:0] R_GT = 3'b100;
  localparam logic [2:0] R_EQ = 3'b010;
  localparam logic [2:0] R_LT = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start1, start0, startn;
  logic        signed_mode;
  logic [15:0] a, b;
  logic [7:0]  a8, b8;
  logic        busy1, done1, gt1, eq1, lt1;
  logic        busy0, done0, gt0, eq0, lt0;
  logic        busyn, donen, gtn, eqn, ltn;
  logic [4:0]  obs1, obs0, obsn;
  logic [2:0]  prev1, prev0, prevn;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  serial_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1)) dut_e1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .signed_mode(signed_mode), .a(a), .b(b),
    .busy(busy1), .done(done1), .gt(gt1), .eq(eq1), .lt(lt1)
  );

  serial_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(0)) dut_e0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .signed_mode(signed_mode), .a(a), .b(b),
    .busy(busy0), .done(done0), .gt(gt0), .eq(eq0), .lt(lt0)
  );

  serial_magnitude_comparator #(.WIDTH(8), .DIGIT(8), .EARLY_EXIT(1)) dut_n1 (
    .clk(clk), .rst_n(rst_n), .start(startn), .signed_mode(signed_mode), .a(a8), .b(b8),
    .busy(busyn), .done(donen), .gt(gtn), .eq(eqn), .lt(ltn)
  );

  assign obs1 = {busy1, done1, gt1, eq1, lt1};
  assign obs0 = {busy0, done0, gt0, eq0, lt0};
  assign obsn = {busyn, donen, gtn, eqn, ltn};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    prev1 = 3'b000; prev0 = 3'b000; prevn = 3'b000;
    tick();
    tick();
    total++;
    if ({obs1, obs0, obsn} !== 15'd0) begin
      bad++; $display("FAIL reset_state obs=%b/%b/%b exp=all zero", obs1, obs0, obsn);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if ({obs1, obs0, obsn} !== 15'd0) begin
      bad++; $display("FAIL reset_release obs=%b/%b/%b exp=all zero", obs1, obs0, obsn);
    end
    $display("reset: obs=%b/%b/%b", obs1, obs0, obsn);
  endtask

  task automatic test_equal();
    logic [4:0] exp;
    a = 16'h1234; b = 16'h1234; signed_mode = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) tick();
      exp = (k < 4) ? {2'b10, prev1} : {2'b01, R_EQ};
      total++;
      if (obs1 !== exp) begin
        bad++; $display("FAIL equal_E%0d obs=%b exp=%b", k, obs1, exp);
      end
    end
    prev1 = R_EQ;
    tick();
    total++;
    if (obs1 !== {2'b00, R_EQ}) begin
      bad++; $display("FAIL equal_hold obs=%b exp=%b", obs1, {2'b00, R_EQ});
    end
    $display("equal 1234/1234: obs=%b", obs1);
  endtask

  task automatic test_early();
    logic [2:0] res;
    for (int m = 0; m < 2; m++) begin
      a = 16'h8000; b = 16'h7FFF; signed_mode = m[0]; start1 = 1'b1;
      res = (m == 0) ? R_GT : R_LT;
      tick();
      start1 = 1'b0;
      total++;
      if (obs1 !== {2'b10, prev1}) begin
        bad++; $display("FAIL early_m%0d_E0 obs=%b exp=%b", m, obs1, {2'b10, prev1});
      end
      tick();
      total++;
      if (obs1 !== {2'b01, res}) begin
        bad++; $display("FAIL early_m%0d_E1 obs=%b exp=%b", m, obs1, {2'b01, res});
      end
      prev1 = res;
      $display("early 8000/7FFF signed=%0d: obs=%b", m, obs1);
      tick();
    end
  endtask

  task automatic test_full_run();
    logic [15:0] va [2];
    logic [15:0] vb [2];
    logic [2:0]  vr [2];
    logic [4:0]  exp;
    va[0] = 16'h00F1; vb[0] = 16'h00F2; vr[0] = R_LT;
    va[1] = 16'h2100; vb[1] = 16'h1F00; vr[1] = R_GT;
    for (int v = 0; v < 2; v++) begin
      a = va[v]; b = vb[v]; signed_mode = 1'b0; start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int k = 0; k <= 4; k++) begin
        if (k > 0) tick();
        exp = (k < 4) ? {2'b10, prev0} : {2'b01, vr[v]};
        total++;
        if (obs0 !== exp) begin
          bad++; $display("FAIL full_v%0d_E%0d obs=%b exp=%b", v, k, obs0, exp);
        end
      end
      prev0 = vr[v];
      $display("full %h/%h: obs=%b", va[v], vb[v], obs0);
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp;
    a = 16'h1111; b = 16'h1111; signed_mode = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      if (k == 2) begin
        // Ignored start plus operand changes while the compare runs.
        start1 = 1'b1; a = 16'h0000; b = 16'hFFFF; signed_mode = 1'b1;
      end
      if (k > 0) tick();
      start1 = 1'b0;
      exp = (k < 4) ? {2'b10, prev1} : {2'b01, R_EQ};
      total++;
      if (obs1 !== exp) begin
        bad++; $display("FAIL b2b_first_E%0d obs=%b exp=%b", k, obs1, exp);
      end
    end
    prev1 = R_EQ;
    $display("b2b first 1111/1111: obs=%b", obs1);
    a = 16'h0001; b = 16'h0002; signed_mode = 1'b0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) tick();
      exp = (k < 4) ? {2'b10, prev1} : {2'b01, R_LT};
      total++;
      if (obs1 !== exp) begin
        bad++; $display("FAIL b2b_second_E%0d obs=%b exp=%b", k, obs1, exp);
      end
    end
    prev1 = R_LT;
    $display("b2b second 0001/0002: obs=%b", obs1);
    tick();
  endtask

  task automatic test_mid_reset();
    a = 16'h5555; b = 16'h5555; signed_mode = 1'b0; start1 = 1'b1; start0 = 1'b1;
    tick();
    start1 = 1'b0; start0 = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    total++;
    if ({obs1, obs0, obsn} !== 15'd0) begin
      bad++; $display("FAIL async_reset obs=%b/%b/%b exp=all zero", obs1, obs0, obsn);
    end
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++;
      if ({obs1, obs0} !== 10'd0) begin
        bad++; $display("FAIL post_reset_idle_%0d obs=%b/%b exp=all zero", k, obs1, obs0);
      end
    end
    prev1 = 3'b000; prev0 = 3'b000; prevn = 3'b000;
    $display("mid-run reset: obs=%b/%b", obs1, obs0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; a = 16'h3000; b = 16'h2FFF; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    total++;
    if (obs1 !== 5'b10000) begin
      bad++; $display("FAIL first_start obs=%b exp=%b", obs1, 5'b10000);
    end
    tick();
    total++;
    if (obs1 !== {2'b01, R_GT}) begin
      bad++; $display("FAIL first_start_result obs=%b exp=%b", obs1, {2'b01, R_GT});
    end
    prev1 = R_GT;
    $display("start after release 3000/2FFF: obs=%b", obs1);
    tick();
  endtask

  task automatic test_n1();
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic       vm [4];
    logic [2:0] vr [4];
    va[0] = 8'h05; vb[0] = 8'h03; vm[0] = 1'b0; vr[0] = R_GT;
    va[1] = 8'h80; vb[1] = 8'h01; vm[1] = 1'b1; vr[1] = R_LT;
    va[2] = 8'h7F; vb[2] = 8'h7F; vm[2] = 1'b1; vr[2] = R_EQ;
    va[3] = 8'h80; vb[3] = 8'h01; vm[3] = 1'b0; vr[3] = R_GT;
    for (int v = 0; v < 4; v++) begin
      a8 = va[v]; b8 = vb[v]; signed_mode = vm[v]; startn = 1'b1;
      tick();
      startn = 1'b0;
      total++;
      if (obsn !== {2'b10, prevn}) begin
        bad++; $display("FAIL n1_v%0d_E0 obs=%b exp=%b", v, obsn, {2'b10, prevn});
      end
      tick();
      total++;
      if (obsn !== {2'b01, vr[v]}) begin
        bad++; $display("FAIL n1_v%0d_E1 obs=%b exp=%b", v, obsn, {2'b01, vr[v]});
      end
      prevn = vr[v];
      $display("n1 %h/%h signed=%0d: obs=%b", va[v], vb[v], vm[v], obsn);
    end
  endtask

  task automatic test_sweep();
    logic [15:0]        ext [6];
    logic signed [15:0] sa, sb;
    logic [2:0]         exp_res;
    int                 cyc1, c;
    int                 kind, nib;
    int                 got1, got0;
    logic               seen1, seen0;
    logic [2:0]         r1, r0;
    ext[0] = 16'h0000; ext[1] = 16'h0001; ext[2] = 16'h7FFF;
    ext[3] = 16'h8000; ext[4] = 16'h8001; ext[5] = 16'hFFFF;
    for (int it = 0; it < 5000; it++) begin
      kind = $urandom_range(0, 3);
      a = 16'($urandom);
      b = 16'($urandom);
      if (kind == 1) b = a;
      if (kind == 2) begin
        nib = $urandom_range(0, 3);
        b = a ^ (16'($urandom_range(1, 15)) << (4 * nib));
      end
      if (kind == 3) begin
        a = ext[$urandom_range(0, 5)];
        b = ext[$urandom_range(0, 5)];
      end
      signed_mode = 1'($urandom_range(0, 1));
      sa = a; sb = b;
      if (signed_mode) exp_res = (sa > sb) ? R_GT : ((sa == sb) ? R_EQ : R_LT);
      else             exp_res = (a > b)   ? R_GT : ((a == b)   ? R_EQ : R_LT);
      cyc1 = 0;
      for (int d = 0; d < 4; d++)
        if (cyc1 == 0 && a[15 - 4 * d -: 4] != b[15 - 4 * d -: 4]) cyc1 = d + 1;
      if (cyc1 == 0) cyc1 = 4;
      start1 = 1'b1; start0 = 1'b1;
      tick();
      start1 = 1'b0; start0 = 1'b0;
      seen1 = 1'b0; seen0 = 1'b0; got1 = 0; got0 = 0; r1 = 3'b000; r0 = 3'b000;
      c = 0;
      while (c < 8 && !(seen1 && seen0)) begin
        tick();
        c++;
        if (!seen1 && done1) begin seen1 = 1'b1; got1 = c; r1 = {gt1, eq1, lt1}; end
        if (!seen0 && done0) begin seen0 = 1'b1; got0 = c; r0 = {gt0, eq0, lt0}; end
      end
      total++;
      if (!seen1 || r1 !== exp_res || got1 != cyc1) begin
        bad++;
        $display("FAIL sweep_e1_%0d a=%h b=%h s=%0d res=%b@%0d exp=%b@%0d", it, a, b, signed_mode, r1, got1, exp_res, cyc1);
      end
      total++;
      if (!seen0 || r0 !== exp_res || got0 != 4) begin
        bad++;
        $display("FAIL sweep_e0_%0d a=%h b=%h s=%0d res=%b@%0d exp=%b@4", it, a, b, signed_mode, r0, got0, exp_res);
      end
      $display("sweep %0d a=%h b=%h s=%0d e1=%b@%0d e0=%b@%0d", it, a, b, signed_mode, r1, got1, r0, got0);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start1 = 1'b0; start0 = 1'b0; startn = 1'b0;
    signed_mode = 1'b0;
    a = '0; b = '0; a8 = '0; b8 = '0;
    test_reset();
    test_equal();
    test_early();
    test_full_run();
    test_back_to_back();
    test_mid_reset();
    test_n1();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
